// File: rtl/slos_receive.sv
// slos_receive: USB4 SLOS1/SLOS2 (PRBS11) receiver that hunts the seed window, tracks and locks.
// Define SLOS_RX_AUTO_POL_EN to take the polarity from the seed window instead of slos1_slos2.
module slos_receive #(
    parameter logic [10:0] SEED       = 11'h400,
    parameter int unsigned DET_ROUNDS = 2,
    parameter int unsigned ERR_MAX    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       data_in,
    input  logic       slos1_slos2,
    output logic       slos_locked,
    output logic       slos_received,
    output logic       round_done,
    output logic       bit_err,
    output logic       slos_type,
    output logic [1:0] dbg_state_o
);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [3:0] ERR_LIM = (ERR_MAX > 15) ? 4'd15 : 4'(ERR_MAX);
    localparam logic [3:0] DET_LIM = (DET_ROUNDS > 15) ? 4'd15 : 4'(DET_ROUNDS);

    logic [1:0]  state_q, state_d;
    logic [9:0]  h_q, h_d;
    logic [3:0]  seen_q, seen_d;
    logic [10:0] lfsr_q, lfsr_d;
    logic        rep_q, rep_d;
    logic [10:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]  err_cnt_q, err_cnt_d;
    logic [3:0]  round_cnt_q, round_cnt_d;
    logic        received_q, received_d;
    logic        round_done_q, round_done_d;
    logic        bit_err_q, bit_err_d;

    logic        pol;
    logic        hunt_bit;
    logic        b;
    logic [10:0] window;
    logic        win_ok;
    logic        match_p;
    logic        found;
    logic        hold;
    logic [10:0] lfsr_step;
    logic        exp_bit;
    logic        mismatch;
    logic        last_bit;
    logic [3:0]  err_sat;
    logic [3:0]  rnd_sat;

`ifdef SLOS_RX_AUTO_POL_EN
    // Hunt on raw line data so both polarities of the seed window are visible.
    logic pol_q, pol_d;
    logic match_n;
    assign pol      = pol_q;
    assign hunt_bit = data_in;
    assign match_n  = win_ok && (window == ~SEED);
    assign found    = match_p || match_n;
`else
    assign pol      = slos1_slos2;
    assign hunt_bit = data_in ^ slos1_slos2;
    assign found    = match_p;
`endif

    assign b         = data_in ^ pol;
    assign window    = {h_q, hunt_bit};
    assign win_ok    = (seen_q >= 4'd10);
    assign match_p   = win_ok && (window == SEED);

    // The seed state is emitted twice per round: once as the hold bit, then the LFSR resumes.
    assign hold      = (lfsr_q == SEED) && !rep_q;
    assign lfsr_step = {lfsr_q[9:0], lfsr_q[10] ^ lfsr_q[8]};
    assign exp_bit   = hold ? lfsr_q[0] : lfsr_step[0];
    assign mismatch  = (b != exp_bit);
    assign last_bit  = (bit_cnt_q == 11'h7FF);
    assign err_sat   = (err_cnt_q == 4'hF) ? 4'hF : err_cnt_q + 4'd1;
    assign rnd_sat   = (round_cnt_q == 4'hF) ? 4'hF : round_cnt_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        h_d          = h_q;
        seen_d       = seen_q;
        lfsr_d       = lfsr_q;
        rep_d        = rep_q;
        bit_cnt_d    = bit_cnt_q;
        err_cnt_d    = err_cnt_q;
        round_cnt_d  = round_cnt_q;
        received_d   = received_q;
        round_done_d = 1'b0;
        bit_err_d    = 1'b0;
`ifdef SLOS_RX_AUTO_POL_EN
        pol_d        = pol_q;
`endif
        if (!enable) begin
            state_d     = ST_HUNT;
            h_d         = '0;
            seen_d      = '0;
            lfsr_d      = SEED;
            rep_d       = 1'b0;
            bit_cnt_d   = '0;
            err_cnt_d   = '0;
            round_cnt_d = '0;
            received_d  = 1'b0;
`ifdef SLOS_RX_AUTO_POL_EN
            pol_d       = 1'b0;
`endif
        end else if (state_q == ST_HUNT) begin
            h_d    = window[9:0];
            seen_d = (seen_q == 4'd11) ? seen_q : seen_q + 4'd1;
            if (found) begin
                state_d   = ST_TRACK;
                lfsr_d    = SEED;
                rep_d     = 1'b0;
                bit_cnt_d = '0;
                err_cnt_d = '0;
`ifdef SLOS_RX_AUTO_POL_EN
                pol_d     = !match_p;
`endif
            end
        end else begin
            if (hold) begin
                rep_d = 1'b1;
            end else begin
                lfsr_d = lfsr_step;
                rep_d  = 1'b0;
            end
            bit_cnt_d = bit_cnt_q + 11'd1;
            bit_err_d = mismatch;
            if (state_q == ST_TRACK) begin
                if (mismatch) begin
                    state_d = ST_HUNT;
                end else if (last_bit) begin
                    state_d     = ST_LOCKED;
                    err_cnt_d   = '0;
                    round_cnt_d = '0;
                end
            end else begin
                if (mismatch) begin
                    err_cnt_d = err_sat;
                end
                if (mismatch && (err_sat > ERR_LIM)) begin
                    state_d = ST_HUNT;
                end else if (last_bit) begin
                    round_done_d = 1'b1;
                    round_cnt_d  = rnd_sat;
                    err_cnt_d    = '0;
                    if (rnd_sat >= DET_LIM) begin
                        received_d = 1'b1;
                    end
                end
            end
            // Losing track or lock restarts the hunt from an empty window.
            if (state_d == ST_HUNT) begin
                h_d         = '0;
                seen_d      = '0;
                lfsr_d      = SEED;
                rep_d       = 1'b0;
                bit_cnt_d   = '0;
                err_cnt_d   = '0;
                round_cnt_d = '0;
                received_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_HUNT;
            h_q          <= '0;
            seen_q       <= '0;
            lfsr_q       <= SEED;
            rep_q        <= 1'b0;
            bit_cnt_q    <= '0;
            err_cnt_q    <= '0;
            round_cnt_q  <= '0;
            received_q   <= 1'b0;
            round_done_q <= 1'b0;
            bit_err_q    <= 1'b0;
`ifdef SLOS_RX_AUTO_POL_EN
            pol_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            h_q          <= h_d;
            seen_q       <= seen_d;
            lfsr_q       <= lfsr_d;
            rep_q        <= rep_d;
            bit_cnt_q    <= bit_cnt_d;
            err_cnt_q    <= err_cnt_d;
            round_cnt_q  <= round_cnt_d;
            received_q   <= received_d;
            round_done_q <= round_done_d;
            bit_err_q    <= bit_err_d;
`ifdef SLOS_RX_AUTO_POL_EN
            pol_q        <= pol_d;
`endif
        end
    end

    assign slos_locked   = (state_q == ST_LOCKED);
    assign slos_received = received_q;
    assign round_done    = round_done_q;
    assign bit_err       = bit_err_q;
    assign dbg_state_o   = state_q;
`ifdef SLOS_RX_AUTO_POL_EN
    assign slos_type     = pol_q;
`else
    assign slos_type     = slos1_slos2;
`endif

endmodule
